cnt_seq_ctrl: RTL and testbench
===============================

# cnt_seq_ctrl

Sequencing controller for one 4-bit binary counter (`cnt_bin`) in the counter lab designs. On each accepted start command it preloads the counter with a start value, runs it for a programmed number of increments, and honours pause and abort requests. It then signals completion. It owns the counter's `set_n`, `stop` and `D` inputs and monitors `cnt` to detect wrap-around.

## Interface
Parameters:
- `WIDTH`, 4, counter width; `load_val`, `run_len`, `D`, `cnt` and `remaining` are all this width.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `sys_clk`  in  1  system clock; all state changes on its rising edge.
  - `sys_rst_n`  in  1  asynchronous active-low reset.
- Command inputs:
  - `start`  in  1  command strobe; sampled only in IDLE.
  - `load_val`  in  WIDTH  preload value; captured when `start` is accepted.
  - `run_len`  in  WIDTH  number of increments to run, 0..15; captured when `start` is accepted.
  - `pause`  in  1  level; holds the counter while the FSM is in RUN.
  - `abort`  in  1  level or pulse; ends any active sequence without `done`.
- Counter feedback:
  - `cnt`  in  WIDTH  current counter value.
- Counter control outputs:
  - `set_n`  out  1  active-low synchronous load strobe to the counter.
  - `stop`  out  1  counter hold request.
  - `D`  out  WIDTH  preload data to the counter.
- Status outputs:
  - `busy`  out  1  high in LOAD, RUN and DONE.
  - `done`  out  1  one-cycle completion pulse.
  - `wrapped`  out  1  sticky flag; counter passed 15→0 during the current or last sequence.
  - `remaining`  out  WIDTH  increments still to run.

## Operation
- Counter contract:
  - `set_n`=0 loads `D` at the clock edge, with priority over `stop`.
  - `stop`=1 holds the count.
  - Otherwise the counter increments modulo 16 at each edge.
- States: IDLE, LOAD, RUN, DONE. Outputs are Moore-decoded from the state register, except `stop` in RUN, which depends on the `pause` input.
  - IDLE: `set_n`=1, `stop`=1. On `start`=1: capture `load_val` and `run_len`, clear `wrapped`, go to LOAD.
  - LOAD: `set_n`=0, `stop`=1, `D`=captured `load_val`. At the next edge load `remaining` with `run_len`. If `run_len`=0 go to DONE, else go to RUN.
  - RUN: `set_n`=1, `stop`=`pause`.
    - Each edge with `pause`=0 is one increment: `remaining` decrements by 1.
    - If `cnt`=15 at that edge, set `wrapped`.
    - When `remaining`=1 and the increment occurs, go to DONE.
  - DONE: `set_n`=1, `stop`=1, `done`=1. Return to IDLE at the next edge.
- `abort`=1 in LOAD, RUN or DONE forces IDLE at the next edge.
  - No `done` pulse; `remaining` is cleared; `wrapped` is held.
  - `abort` has priority over completion and `pause`.
- `start` is ignored while `busy`=1; no queuing.
- `D` holds the last captured `load_val` in all states.
- Final count after an uninterrupted sequence = (`load_val` + `run_len`) mod 16.

## Timing
- Reset values: state=IDLE, `set_n`=1, `stop`=1, `D`=0, `busy`=0, `done`=0, `wrapped`=0, `remaining`=0, captured registers=0.
- Cycle-level sequence with `start` accepted at edge E0 and no pause:
  - LOAD occupies the cycle after E0.
  - The counter equals `load_val` after E1.
  - Increments happen at edges E2 .. E(1+`run_len`).
  - `done` is high for the cycle after E(1+`run_len`).
  - The FSM is back in IDLE after E(2+`run_len`).
  - `busy` is high for `run_len`+2 cycles.
- Pause: each RUN cycle with `pause`=1 delays completion by exactly one cycle. `cnt` and `remaining` are unchanged during that cycle.
- `pause` is ignored outside RUN. `pause`=1 on the final increment cycle defers DONE until the increment occurs.
- Reset assertion mid-sequence immediately forces all outputs to their reset values, asynchronously. The counter is reset by the same `sys_rst_n`.
- A `start` in the same cycle DONE→IDLE occurs is ignored. It is accepted only when the FSM is already in IDLE at the sampling edge.

## Test plan
- Reset, then `start` with `load_val`=3, `run_len`=5:
  - `cnt`=3 after E1 and increments 4..8.
  - `done` pulses once with `cnt`=8 and `remaining`=0.
  - `busy` is high for 7 cycles; `wrapped`=0.
- Wrap: `load_val`=14, `run_len`=4:
  - `cnt` goes 14,15,0,1,2 and ends at 2.
  - `wrapped`=1 and stays 1 until the next accepted `start`.
- Pause: `load_val`=3, `run_len`=5, `pause` high for 2 cycles after the second increment:
  - `cnt` holds at 5 for 2 cycles.
  - `done` arrives 2 cycles later than in the unpaused case; final `cnt`=8.
- Zero length: `load_val`=9, `run_len`=0:
  - LOAD→DONE; `cnt`=9.
  - `busy` is high for 2 cycles; `done` pulses once.
- Abort and start-while-busy: `start` with `load_val`=0, `run_len`=10; a second `start` with `load_val`=7 after 2 increments; `abort` after 3 increments:
  - The second `start` is ignored.
  - After `abort`: IDLE, `cnt` holds 3, no `done`, `remaining`=0.
- Reset mid-RUN: assert `sys_rst_n`=0 after 2 increments of a `run_len`=8 sequence:
  - All outputs go to reset values without waiting for a clock edge, and `cnt`=0.
  - A new `start` after release runs normally.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequencing controller for one external binary counter.
// On an accepted start it preloads the counter (set_n low for one cycle),
// lets it run for run_len increments, honours pause/abort, then pulses done.
//
// Ports
//   sys_clk, sys_rst_n        clock, async active-low reset
//   start, load_val, run_len  command (sampled only in IDLE)
//   pause                     hold counter while in RUN
//   abort                     end active sequence without done
//   cnt                       counter feedback (wrap detection)
//   set_n, stop, D            counter control
//   busy, done, wrapped       status
//   remaining                 increments still to run
module cnt_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] run_len,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt,
  output logic             set_n,
  output logic             stop,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] ld_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] rem_q;
  logic             wrap_q;

  // An increment happens on every RUN edge the counter is not held.
  logic inc;
  assign inc = (state_q == RUN) && !pause;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ld_q    <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ld_q    <= load_val;
            len_q   <= run_len;
            wrap_q  <= 1'b0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            rem_q   <= '0;
            state_q <= IDLE;
          end else begin
            rem_q   <= len_q;
            state_q <= (len_q == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // abort wins over both pause and completion; wrapped is left as is
          if (abort) begin
            rem_q   <= '0;
            state_q <= IDLE;
          end else if (inc) begin
            rem_q <= rem_q - WIDTH'(1);
            if (cnt == {WIDTH{1'b1}}) wrap_q <= 1'b1;
            if (rem_q == WIDTH'(1)) state_q <= DONE;
          end
        end
        DONE: begin
          // start is not sampled here, so a start on this edge is dropped
          if (abort) rem_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode from the state register; only stop in RUN follows pause.
  assign set_n     = (state_q != LOAD);
  assign stop      = (state_q == RUN) ? pause : 1'b1;
  assign D         = ld_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign wrapped   = wrap_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
module tb_cnt_seq_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] run_len = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cnt;
  logic       set_n, stop, busy, done, wrapped;
  logic [3:0] D, remaining;

  int checks = 0;
  int errors = 0;

  // per-run observation record, indexed by edges after the start edge
  logic [3:0] cnt_h [0:39];
  logic [3:0] rem_h [0:39];
  int busy_n, done_n, done_at;

  cnt_seq_ctrl #(.WIDTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .load_val(load_val), .run_len(run_len), .pause(pause), .abort(abort),
    .cnt(cnt), .set_n(set_n), .stop(stop), .D(D), .busy(busy),
    .done(done), .wrapped(wrapped), .remaining(remaining)
  );

  // behavioural model of the 4-bit counter being controlled
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  cnt <= '0;
    else if (!set_n) cnt <= D;
    else if (!stop)  cnt <= cnt + 4'd1;
  end

  initial forever #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Issue a start and record until the FSM is back in IDLE (bounded).
  // pause is high during cycles ps .. ps+pl-1 (affecting the following edges).
  task automatic run_seq(input logic [3:0] lv, input logic [3:0] rl, input int ps, input int pl);
    load_val = lv; run_len = rl; start = 1'b1;
    step();
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      cnt_h[c] = cnt; rem_h[c] = remaining;
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = c; end
      if (!busy) break;
      pause = (c >= ps) && (c < ps + pl);
      step();
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (set_n !== 1'b1 || stop !== 1'b1) begin errors++; $display("FAIL rst_ctrl got set_n=%b stop=%b exp 1 1", set_n, stop); end
    checks++; if (D !== 4'd0 || remaining !== 4'd0) begin errors++; $display("FAIL rst_data got D=%0d rem=%0d exp 0 0", D, remaining); end
    checks++; if (done !== 1'b0 || wrapped !== 1'b0) begin errors++; $display("FAIL rst_flags got done=%b wrapped=%b exp 0 0", done, wrapped); end
    sys_rst_n = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0 || cnt !== 4'd0) begin errors++; $display("FAIL rst_idle got busy=%b cnt=%0d exp 0 0", busy, cnt); end
  endtask

  task automatic test_basic();
    run_seq(4'd3, 4'd5, 99, 0);
    checks++; if (cnt_h[0] !== 4'd0) begin errors++; $display("FAIL basic_preload_cyc got %0d exp 0", cnt_h[0]); end
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (cnt_h[k] !== 4'(2 + k)) begin errors++; $display("FAIL basic_cnt[%0d] got %0d exp %0d", k, cnt_h[k], 2 + k); end
    end
    checks++; if (done_n !== 1 || done_at !== 6) begin errors++; $display("FAIL basic_done got n=%0d at=%0d exp 1 6", done_n, done_at); end
    checks++; if (rem_h[6] !== 4'd0) begin errors++; $display("FAIL basic_rem_done got %0d exp 0", rem_h[6]); end
    checks++; if (busy_n !== 7) begin errors++; $display("FAIL basic_busy got %0d exp 7", busy_n); end
    checks++; if (wrapped !== 1'b0 || cnt !== 4'd8) begin errors++; $display("FAIL basic_end got wrapped=%b cnt=%0d exp 0 8", wrapped, cnt); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_c [0:4];
    exp_c = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    run_seq(4'd14, 4'd4, 99, 0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cnt_h[k + 1] !== exp_c[k]) begin errors++; $display("FAIL wrap_cnt[%0d] got %0d exp %0d", k + 1, cnt_h[k + 1], exp_c[k]); end
    end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag got %b exp 1", wrapped); end
    step(); step(); step();
    checks++; if (wrapped !== 1'b1 || cnt !== 4'd2) begin errors++; $display("FAIL wrap_sticky got wrapped=%b cnt=%0d exp 1 2", wrapped, cnt); end
  endtask

  task automatic test_zero_len();
    run_seq(4'd9, 4'd0, 99, 0);
    checks++; if (busy_n !== 2) begin errors++; $display("FAIL zero_busy got %0d exp 2", busy_n); end
    checks++; if (done_n !== 1 || done_at !== 1) begin errors++; $display("FAIL zero_done got n=%0d at=%0d exp 1 1", done_n, done_at); end
    checks++; if (cnt_h[1] !== 4'd9 || cnt !== 4'd9) begin errors++; $display("FAIL zero_cnt got %0d/%0d exp 9", cnt_h[1], cnt); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL zero_wrap_clr got %b exp 0", wrapped); end
  endtask

  task automatic test_pause();
    run_seq(4'd3, 4'd5, 3, 2);
    for (int k = 3; k <= 5; k++) begin
      checks++;
      if (cnt_h[k] !== 4'd5 || rem_h[k] !== 4'd3) begin errors++; $display("FAIL pause_hold[%0d] got cnt=%0d rem=%0d exp 5 3", k, cnt_h[k], rem_h[k]); end
    end
    checks++; if (cnt_h[6] !== 4'd6) begin errors++; $display("FAIL pause_resume got %0d exp 6", cnt_h[6]); end
    checks++; if (done_n !== 1 || done_at !== 8) begin errors++; $display("FAIL pause_done got n=%0d at=%0d exp 1 8", done_n, done_at); end
    checks++; if (cnt_h[8] !== 4'd8 || busy_n !== 9) begin errors++; $display("FAIL pause_end got cnt=%0d busy=%0d exp 8 9", cnt_h[8], busy_n); end
  endtask

  task automatic test_abort();
    int dseen = 0;
    load_val = 4'd0; run_len = 4'd10; start = 1'b1;
    step();                           // E0 -> LOAD
    start = 1'b0;
    step(); step();                   // E1 cnt=0, E2 cnt=1
    // second start sampled at E3 while RUN
    load_val = 4'd7; run_len = 4'd2; start = 1'b1;
    step();                           // E3 cnt=2
    start = 1'b0;
    checks++; if (D !== 4'd0 || busy !== 1'b1 || set_n !== 1'b1) begin errors++; $display("FAIL abort_ign_start got D=%0d busy=%b set_n=%b exp 0 1 1", D, busy, set_n); end
    checks++; if (cnt !== 4'd2 || remaining !== 4'd8) begin errors++; $display("FAIL abort_mid got cnt=%0d rem=%0d exp 2 8", cnt, remaining); end
    abort = 1'b1;                     // sampled at the third increment edge
    step();
    abort = 1'b0;
    if (done) dseen++;
    checks++; if (busy !== 1'b0 || remaining !== 4'd0) begin errors++; $display("FAIL abort_idle got busy=%b rem=%0d exp 0 0", busy, remaining); end
    checks++; if (cnt !== 4'd3) begin errors++; $display("FAIL abort_cnt got %0d exp 3", cnt); end
    step(); if (done) dseen++;
    step(); if (done) dseen++;
    checks++; if (cnt !== 4'd3 || dseen !== 0) begin errors++; $display("FAIL abort_hold got cnt=%0d dones=%0d exp 3 0", cnt, dseen); end
  endtask

  task automatic test_back_to_back();
    load_val = 4'd9; run_len = 4'd0; start = 1'b1;
    step();                           // E0 -> LOAD
    load_val = 4'd4;                  // start held high through LOAD and DONE
    step();                           // E1 -> DONE
    step();                           // E2 -> IDLE, start ignored in DONE
    checks++; if (busy !== 1'b0 || D !== 4'd9) begin errors++; $display("FAIL b2b_ignore got busy=%b D=%0d exp 0 9", busy, D); end
    step();                           // E3 accepted in IDLE
    start = 1'b0;
    checks++; if (busy !== 1'b1 || set_n !== 1'b0 || D !== 4'd4) begin errors++; $display("FAIL b2b_accept got busy=%b set_n=%b D=%0d exp 1 0 4", busy, set_n, D); end
    step(); step(); step();
    checks++; if (busy !== 1'b0 || cnt !== 4'd4) begin errors++; $display("FAIL b2b_end got busy=%b cnt=%0d exp 0 4", busy, cnt); end
  endtask

  task automatic test_reset_mid();
    load_val = 4'd5; run_len = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();           // two increments done, cnt=7
    checks++; if (cnt !== 4'd7 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre got cnt=%0d busy=%b exp 7 1", cnt, busy); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || wrapped !== 1'b0) begin errors++; $display("FAIL rmid_status got busy=%b done=%b wrapped=%b exp 0 0 0", busy, done, wrapped); end
    checks++; if (set_n !== 1'b1 || stop !== 1'b1) begin errors++; $display("FAIL rmid_ctrl got set_n=%b stop=%b exp 1 1", set_n, stop); end
    checks++; if (D !== 4'd0 || remaining !== 4'd0 || cnt !== 4'd0) begin errors++; $display("FAIL rmid_data got D=%0d rem=%0d cnt=%0d exp 0 0 0", D, remaining, cnt); end
    #2 sys_rst_n = 1'b1;
    step();
    run_seq(4'd2, 4'd3, 99, 0);
    checks++; if (cnt_h[1] !== 4'd2 || cnt_h[4] !== 4'd5) begin errors++; $display("FAIL rmid_rerun_cnt got %0d..%0d exp 2..5", cnt_h[1], cnt_h[4]); end
    checks++; if (done_n !== 1 || done_at !== 4 || busy_n !== 5) begin errors++; $display("FAIL rmid_rerun got done_n=%0d at=%0d busy=%0d exp 1 4 5", done_n, done_at, busy_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_pause();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
